// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the dual-clock FIFO. Pops first-word-fall-through words,
// re-presents them as a registered valid/ready stream through a 2-entry skid buffer,
// frames them into packets of programmable length and counts completed packets.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  busy
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} buf_state_e;

  buf_state_e            state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;

  logic                  pop;
  logic                  acc;
  logic [LEN_WIDTH-1:0]  len_new;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic                  pop_last;

  // Never pop while the skid holds a word, so at most two words are ever buffered.
  assign pop = enable & ~fifo_empty & ~skid_valid_q;
  assign acc = out_valid_q & m_ready;

  // Packet framing: latch the length on the first pop and tag the final word.
  always_comb begin
    len_new    = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    len_eff    = (word_cnt_q == '0) ? len_new : len_q;
    pop_last   = (word_cnt_q == (len_eff - LEN_WIDTH'(1)));
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    if (pop) begin
      if (word_cnt_q == '0) begin
        len_d = len_new;
      end
      word_cnt_d = pop_last ? '0 : (word_cnt_q + LEN_WIDTH'(1));
    end
  end

  // Skid-buffer next state; the last bit travels alongside its data word.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    unique case (state_q)
      StEmpty: begin
        if (pop) begin
          state_d    = StOne;
          out_data_d = fifo_rd_data;
          out_last_d = pop_last;
        end
      end
      StOne: begin
        if (pop && acc) begin
          out_data_d = fifo_rd_data;
          out_last_d = pop_last;
        end else if (pop) begin
          state_d     = StTwo;
          skid_data_d = fifo_rd_data;
          skid_last_d = pop_last;
        end else if (acc) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (acc) begin
          state_d    = StOne;
          out_data_d = skid_data_q;
          out_last_d = skid_last_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    out_valid_d  = (state_d != StEmpty);
    skid_valid_d = (state_d == StTwo);
  end

  // Completed-packet counter, wraps naturally.
  always_comb begin
    pkt_count_d = pkt_count_q + CNT_WIDTH'(acc && out_last_q);
  end

  // State registers; reset discards any buffered words.
  always_ff @(posedge rd_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StEmpty;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      word_cnt_q   <= word_cnt_d;
      len_q        <= len_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign fifo_rd_en = pop;
  assign m_valid    = out_valid_q;
  assign m_data     = out_data_q;
  assign m_last     = out_last_q;
  assign pkt_count  = pkt_count_q;
  assign busy       = out_valid_q | skid_valid_q | (word_cnt_q != '0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a queue models the FWFT FIFO, accepted
// words are logged and compared against hand-computed expectations.
module tb_fifo_stream_reader;

  logic        rd_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  pkt_len;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;
  logic [15:0] pkt_count;
  logic        busy;

  logic        w_enable;
  logic        w_fifo_rd_en;
  logic        w_m_valid;
  logic        w_m_ready;
  logic [7:0]  w_m_data;
  logic        w_m_last;
  logic [3:0]  w_pkt_count;
  logic        w_busy;

  logic        empty_force;
  logic [7:0]  fq[$];
  logic [7:0]  rq_data[$];
  logic        rq_last[$];
  int          rq_cyc[$];
  int          cyc;
  int          pop_cnt;
  int          w_acc;
  int          checks;
  int          errors;

  fifo_stream_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rd_clk(rd_clk), .reset_n(reset_n), .enable(enable), .pkt_len(pkt_len),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .pkt_count(pkt_count), .busy(busy)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8), .CNT_WIDTH(4)) dut_wrap (
    .rd_clk(rd_clk), .reset_n(reset_n), .enable(w_enable), .pkt_len(8'd1),
    .fifo_empty(1'b0), .fifo_rd_data(8'hA5), .fifo_rd_en(w_fifo_rd_en),
    .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data), .m_last(w_m_last),
    .pkt_count(w_pkt_count), .busy(w_busy)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_drive();
    fifo_empty   = empty_force || (fq.size() == 0);
    fifo_rd_data = (fq.size() > 0) ? fq[0] : 8'h00;
  endtask

  task automatic push_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
    fifo_drive();
  endtask

  task automatic clear_rx();
    rq_data.delete();
    rq_last.delete();
    rq_cyc.delete();
    pop_cnt = 0;
  endtask

  // Observe on the falling edge what the next rising edge will act on.
  task automatic tick();
    logic do_pop;
    @(negedge rd_clk);
    do_pop = fifo_rd_en;
    if (m_valid && m_ready) begin
      rq_data.push_back(m_data);
      rq_last.push_back(m_last);
      rq_cyc.push_back(cyc);
    end
    if (w_m_valid && w_m_ready) w_acc++;
    @(posedge rd_clk);
    #1;
    cyc++;
    if (do_pop && fq.size() > 0) begin
      fq.delete(0);
      pop_cnt++;
    end
    fifo_drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_stream(input string tag, input logic [7:0] base, input int n,
                              input int plen);
    check({tag, "_count"}, rq_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rq_data.size()) begin
        check($sformatf("%s_data%0d", tag, i), rq_data[i], base + 8'(i));
        check($sformatf("%s_last%0d", tag, i), rq_last[i], ((i % plen) == plen - 1));
      end
    end
  endtask

  initial begin
    int bad;
    int nlast;
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    w_acc       = 0;
    pop_cnt     = 0;
    reset_n     = 1'b0;
    enable      = 1'b0;
    pkt_len     = 8'd4;
    m_ready     = 1'b0;
    empty_force = 1'b0;
    w_enable    = 1'b0;
    w_m_ready   = 1'b1;
    fifo_drive();
    ticks(2);

    // Reset state
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_last", m_last, 0);
    check("rst_count", pkt_count, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    ticks(1);

    // Basic framing at full rate
    clear_rx();
    enable  = 1'b1;
    m_ready = 1'b1;
    pkt_len = 8'd4;
    push_words(8'h10, 8);
    tick();
    check("latency_valid", m_valid, 1);
    check("latency_data", m_data, 8'h10);
    ticks(11);
    check_stream("basic", 8'h10, 8, 4);
    if (rq_cyc.size() >= 8) check("basic_throughput", rq_cyc[7] - rq_cyc[0], 7);
    check("basic_count", pkt_count, 2);
    check("basic_busy", busy, 0);

    // Backpressure: only two words may be popped while stalled
    clear_rx();
    m_ready = 1'b0;
    push_words(8'h10, 8);
    ticks(6);
    check("bp_pops", pop_cnt, 2);
    check("bp_valid", m_valid, 1);
    check("bp_hold_data", m_data, 8'h10);
    check("bp_no_pop", fifo_rd_en, 0);
    m_ready = 1'b1;
    ticks(12);
    check_stream("bp", 8'h10, 8, 4);
    check("bp_count", pkt_count, 4);

    // pkt_len = 0 behaves as 1
    clear_rx();
    pkt_len = 8'd0;
    push_words(8'h20, 4);
    ticks(8);
    check_stream("len0", 8'h20, 4, 1);
    check("len0_count", pkt_count, 8);

    // Length change mid-packet applies only to the next packet
    clear_rx();
    pkt_len = 8'd4;
    push_words(8'h30, 6);
    ticks(2);
    pkt_len = 8'd2;
    ticks(8);
    check("chg_count_words", rq_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rq_data.size()) begin
        check($sformatf("chg_data%0d", i), rq_data[i], 8'h30 + 8'(i));
        check($sformatf("chg_last%0d", i), rq_last[i], (i == 3 || i == 5));
      end
    end
    check("chg_count", pkt_count, 10);

    // pkt_len = 255: single last on word 255
    clear_rx();
    pkt_len = 8'd255;
    push_words(8'h00, 255);
    ticks(262);
    check("l255_words", rq_data.size(), 255);
    bad   = 0;
    nlast = 0;
    for (int i = 0; i < rq_data.size(); i++) begin
      if (rq_data[i] !== 8'(i)) bad++;
      if (rq_last[i]) nlast++;
    end
    check("l255_data_bad", bad, 0);
    check("l255_nlast", nlast, 1);
    if (rq_last.size() == 255) check("l255_last_pos", rq_last[254], 1);
    check("l255_count", pkt_count, 11);

    // enable low mid-packet: drain buffered words, keep word count
    clear_rx();
    pkt_len = 8'd4;
    push_words(8'h40, 8);
    ticks(2);
    enable = 1'b0;
    #1;
    check("en_rd_en_off", fifo_rd_en, 0);
    ticks(4);
    check("en_drained", m_valid, 0);
    check("en_busy", busy, 1);
    check("en_drain_cnt", rq_data.size(), 2);
    enable = 1'b1;
    ticks(10);
    check_stream("en", 8'h40, 8, 4);
    check("en_count", pkt_count, 13);

    // fifo_empty toggling with intermittent backpressure
    clear_rx();
    push_words(8'h50, 8);
    for (int i = 0; i < 30; i++) begin
      empty_force = (i % 2) == 1;
      m_ready     = (i % 3) != 2;
      fifo_drive();
      tick();
    end
    empty_force = 1'b0;
    m_ready     = 1'b1;
    fifo_drive();
    ticks(12);
    check_stream("tog", 8'h50, 8, 4);
    check("tog_count", pkt_count, 15);

    // Asynchronous reset while both buffer entries are full mid-packet
    clear_rx();
    m_ready = 1'b0;
    push_words(8'h60, 6);
    ticks(2);
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_rd_en", fifo_rd_en, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_last", m_last, 0);
    check("arst_count", pkt_count, 0);
    check("arst_busy", busy, 0);
    fq.delete();
    fifo_drive();
    ticks(2);
    reset_n = 1'b1;
    ticks(1);
    clear_rx();
    m_ready = 1'b1;
    push_words(8'h70, 8);
    ticks(12);
    check_stream("post_rst", 8'h70, 8, 4);
    check("post_rst_count", pkt_count, 2);

    // 4-bit counter wraps after 16 single-word packets
    w_acc    = 0;
    w_enable = 1'b1;
    ticks(17);
    check("wrap_acc16", w_acc, 16);
    check("wrap_count16", w_pkt_count, 0);
    check("wrap_last", w_m_last, 1);
    w_enable = 1'b0;
    #1;
    check("wrap_rd_en_off", w_fifo_rd_en, 0);
    ticks(3);
    check("wrap_acc17", w_acc, 17);
    check("wrap_count17", w_pkt_count, 1);
    check("wrap_data", w_m_data, 8'hA5);
    check("wrap_busy", w_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side consumer for the team's dual-clock FIFO, living entirely in the read clock domain.
- Drives the FIFO's read port: rd_en, first-word-fall-through rd_data, empty flag.
- Re-presents the words as a registered valid/ready stream with a 2-entry skid buffer, so full throughput holds under backpressure.
- Frames the stream into packets of a runtime-programmable length, asserts m_last on the final word of each packet, and counts completed packets.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and of the output stream data.
- LEN_WIDTH, 8, width of the pkt_len input and of the internal word counter.
- CNT_WIDTH, 16, width of the pkt_count status counter.

Ports:
- rd_clk  input  1  single clock; same clock as the FIFO read side.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  high permits popping from the FIFO.
- pkt_len  input  LEN_WIDTH  words per packet, sampled on the first pop of each packet; 0 is treated as 1.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0.
- fifo_rd_en  output  1  FIFO pop strobe.
- m_valid  output  1  output stream valid.
- m_ready  input  1  downstream ready.
- m_data  output  DATA_WIDTH  output stream data.
- m_last  output  1  final word of the current packet.
- pkt_count  output  CNT_WIDTH  number of packets fully accepted downstream.
- busy  output  1  high when any word is buffered or a packet is partially popped.

Behaviour:
- Reset (reset_n=0, async) clears everything to 0: m_valid, m_data, m_last, skid valid/data/last, word_cnt, latched length, pkt_count, busy.
- Buffered words are discarded on reset; the FIFO is reset by its own logic.
- Pop rule (combinational): fifo_rd_en = enable & ~fifo_empty & ~skid_valid. A pop consumes fifo_rd_data in the same cycle.
- Buffer state machine has three states:
  - EMPTY: m_valid=0.
  - ONE: out register full, skid empty.
  - TWO: both full.
- Buffer transitions per cycle (pop = fifo_rd_en, acc = m_valid & m_ready):
  - EMPTY + pop -> ONE; word loaded into the out register.
  - ONE + pop & acc -> ONE; out register reloaded with the new word.
  - ONE + pop & ~acc -> TWO; new word loaded into skid.
  - ONE + ~pop & acc -> EMPTY.
  - TWO + acc -> ONE; out register <- skid. No pop occurs, since skid_valid=1.
  - TWO + ~acc -> hold.
- All m_* outputs come straight from registers. m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Latency: word at FIFO head with enable=1 and state EMPTY -> m_valid=1 on the next rising edge.
- Throughput: with m_ready held high, one word per cycle.
- Framing:
  - On a pop with word_cnt=0, latch len = (pkt_len==0 ? 1 : pkt_len).
  - The popped word's last bit = (word_cnt == effective_len-1), using the freshly latched len on the first pop.
  - word_cnt increments on each pop and returns to 0 after the last pop.
  - The last bit travels with the word through out/skid.
- pkt_len changes mid-packet are ignored until the next packet starts.
- enable=0 stops popping immediately, even mid-packet. Already-buffered words still drain. word_cnt is kept, and framing resumes when enable returns.
- pkt_count increments by 1 on each acc with m_last=1. It wraps modulo 2^CNT_WIDTH.
- busy = m_valid | skid_valid | (word_cnt != 0).
- Simultaneous events:
  - fifo_empty rising in the same cycle as acc: no pop, buffer drains normally.
  - fifo_empty deasserting while in state TWO: no pop until skid clears.

Test Plan:
- Basic: pkt_len=4, m_ready=1, FIFO holds 0x10..0x17 -> m_data 0x10..0x17 on consecutive cycles; m_last high on 0x13 and 0x17; pkt_count=2; busy=0 at the end.
- Backpressure: m_ready=0 for 5 cycles after the first word -> exactly 2 pops occur; m_data holds 0x10. Release m_ready -> 0x10, 0x11, 0x12... with no loss, duplication or reorder.
- Length boundaries:
  - pkt_len=0 -> every word has m_last=1; pkt_count increments per word.
  - pkt_len=255 -> m_last only on word 255.
  - pkt_len changed from 4 to 2 after the 2nd word of a packet -> that packet still ends on word 4; the next packet ends on word 2.
- Enable/empty: enable=0 mid-packet -> fifo_rd_en=0, buffered words drain, busy stays 1 (word_cnt!=0). Re-enable -> m_last lands on the correct word. fifo_empty toggling every cycle -> data integrity preserved.
- Reset mid-operation: assert reset_n=0 while in state TWO mid-packet -> m_valid, m_last, pkt_count, busy go 0 immediately (asynchronously). After release, the next packet is framed from word 0.
- Counter wrap, with CNT_WIDTH=4 and pkt_len=1: after 17 accepted words -> pkt_count=1.
